mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Load/store unit directly upstream of the 32-bit byte-addressable data memory. It accepts one pipeline memory request at a time (byte, halfword or word; signed or unsigned loads) over a valid/ready handshake.
- Drives the memory's word-wide port with word-aligned addresses. Sub-word stores are done as read-modify-write (RMW) sequences, because the memory always writes all 4 bytes.
- Returns formatted load data, or an error for misaligned or illegal requests, over a registered response channel.

Parameters:
- ADDR_LIMIT, 32'h20000, byte size of the backing memory. Any access with addr+3 >= ADDR_LIMIT is an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_wr  in  1  1=store, 0=load
- req_size  in  2  access size code (see package)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load result, zero for stores and errors
- resp_err  out  1  misaligned, out of range, or reserved size
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_addr  out  32  to memory addr, always {addr[31:2],2'b00}
- mem_wdata  out  32  to memory data_in
- mem_rdata  in  32  from memory data_out; combinational, valid in the same cycle

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - req_ready=0 while in reset.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - All request registers cleared.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1.
  - On req_valid&req_ready, latch wr, size, signed, addr and wdata. Then check the request, in this priority:
  - size=2'b11 -> RESP with err=1.
  - Half with addr[0]!=0, or word with addr[1:0]!=0 -> RESP with err=1.
  - addr+3 >= ADDR_LIMIT -> RESP with err=1.
  - Load -> LOAD.
  - Word store -> STORE.
  - Byte or half store -> RMW_RD.
- LOAD: mem_enable=1, mem_wr=0.
  - Extract the lane from mem_rdata: byte lane = addr[1:0], half lane = addr[1]; little-endian, lane k = bits[8k+7:8k].
  - Zero- or sign-extend, register into resp_rdata, go to RESP.
- STORE: mem_enable=1, mem_wr=1, mem_wdata=wdata. The write occurs on this edge; go to RESP.
- RMW_RD: mem_enable=1, mem_wr=0.
  - Capture mem_rdata, with the target lane replaced by wdata[7:0] or wdata[15:0], into a merge register.
  - Go to RMW_WR.
- RMW_WR: mem_enable=1, mem_wr=1, mem_wdata=merge register; go to RESP.
- Memory-port idle values: in every state other than LOAD, STORE, RMW_RD and RMW_WR, mem_enable=0 and mem_wr=0. The memory never sees read and write in the same cycle.
- RESP: resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_ready=1.
  - Then go to IDLE and clear resp_valid.
  - req_ready=0 in RESP, so there is no accept-while-responding; throughput is one request per 3–4 cycles.
- Latency from the accept edge to resp_valid:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Stores return resp_rdata=0. Errors never assert mem_enable.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_enable drops asynchronously.
  - If reset lands in RMW_RD, or in RMW_WR before the edge, memory is untouched; there are no partial writes.
  - A pending response is discarded.
- Request inputs are ignored outside IDLE.

Decomposition:
- Package mem_access_pkg:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - State encoding constants for the six states.
- Sub-module mem_lane_fmt (combinational).
  - Load path inputs: word, addr[1:0], size, signed -> extracted/extended data.
  - Store path inputs: word, wdata, addr[1:0], size -> merged data.
  - Used by LOAD and RMW_RD.

Test Plan:
- Memory word at 0x100 preloaded to 0x8899AABB; load byte, signed, 0x101 -> resp_rdata=0xFFFFFFAA, err=0, resp_valid 2 cycles after accept, mem_addr=0x100.
- Same preload; load half, unsigned, 0x102 -> 0x00008899; load word 0x100 -> 0x8899AABB.
- Store half 0x00001234 to 0x102 -> mem_enable/wr=0 then 1 on consecutive cycles; word 0x100 becomes 0x1234AABB; resp_valid 3 cycles after accept.
- Load word 0x102; store half 0x101; size 2'b11; load word 0x1FFFE -> each gives resp_err=1 after 1 cycle, mem_enable never 1, memory unchanged.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0; new req_valid is ignored until the handshake completes.
- Store byte 0x55 to 0x103; assert rst=0 during RMW_WR before the edge -> outputs reset immediately, word 0x100 unchanged, next request after reset completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access-size codes, FSM states
// and the alignment rule used when a request is accepted.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_fmt.sv
// Byte-lane steering between the 32-bit memory word and sub-word accesses:
// extracts/extends load data and merges store data into a read word.
module mem_lane_fmt
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] mask;

  // Little-endian lanes: byte k lives at bits [8k+7:8k].
  always_comb begin
    byte_sh   = {addr_i, 3'b000};
    half_sh   = {addr_i[1], 4'b0000};
    byte_lane = 8'(word_i >> byte_sh);
    half_lane = 16'(word_i >> half_sh);
    mask      = 32'h0;
    load_o    = word_i;
    merge_o   = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & byte_lane[7]}}, byte_lane};
        mask    = 32'h0000_00FF << byte_sh;
        merge_o = (word_i & ~mask) | ((32'(wdata_i[7:0]) << byte_sh) & mask);
      end
      SZ_HALF: begin
        load_o  = {{16{signed_i & half_lane[15]}}, half_lane};
        mask    = 32'h0000_FFFF << half_sh;
        merge_o = (word_i & ~mask) | ((32'(wdata_i[15:0]) << half_sh) & mask);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit in front of a word-wide data memory: one request at a time,
// sub-word stores as read-modify-write, registered response channel.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h20000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_enable_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_enable_q;
  logic        mem_wr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] fmt_load;
  logic [31:0] fmt_merge;
  logic [32:0] last_byte;
  logic        req_bad;

  mem_lane_fmt u_fmt (
    .word_i   (mem_rdata_i),
    .wdata_i  (wdata_q),
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .load_o   (fmt_load),
    .merge_o  (fmt_merge)
  );

  // 33-bit sum so addresses near 2^32 cannot wrap past the range check.
  assign last_byte = {1'b0, req_addr_i} + 33'd3;
  assign req_bad   = (req_size_i == SZ_RSVD) || misaligned(req_size_i, req_addr_i[1:0]) ||
                     (last_byte >= {1'b0, ADDR_LIMIT});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q  <= 1'b0;
            size_q       <= req_size_i;
            signed_q     <= req_signed_i;
            addr_q       <= req_addr_i;
            wdata_q      <= req_wdata_i;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            if (req_bad) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_wr_i) begin
              state_q      <= ST_LOAD;
              mem_enable_q <= 1'b1;
              mem_wr_q     <= 1'b0;
            end else if (req_size_i == SZ_WORD) begin
              state_q      <= ST_STORE;
              mem_enable_q <= 1'b1;
              mem_wr_q     <= 1'b1;
              mem_wdata_q  <= req_wdata_i;
            end else begin
              state_q      <= ST_RMW_RD;
              mem_enable_q <= 1'b1;
              mem_wr_q     <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata_q <= fmt_load;
          resp_valid_q <= 1'b1;
          mem_enable_q <= 1'b0;
          state_q      <= ST_RESP;
        end
        ST_STORE, ST_RMW_WR: begin
          resp_valid_q <= 1'b1;
          mem_enable_q <= 1'b0;
          mem_wr_q     <= 1'b0;
          state_q      <= ST_RESP;
        end
        // mem_wdata_q doubles as the merge register for the write-back cycle.
        ST_RMW_RD: begin
          mem_wdata_q <= fmt_merge;
          mem_wr_q    <= 1'b1;
          state_q     <= ST_RMW_WR;
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          mem_enable_q <= 1'b0;
          mem_wr_q     <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wdata_o  = mem_wdata_q;

endmodule
